// File: rtl/multi_channel_interval_timer_if.sv
// Avalon-MM slave bus bundle for multi_channel_interval_timer.
// Ports (slave view):
//   address    in   {channel, reg[2:0]}, $clog2(NUM_CH)+3 bits
//   chipselect in   slave select
//   write_n    in   active-low write strobe
//   writedata  in   32-bit write data
//   readdata   out  32-bit registered read data
interface multi_channel_interval_timer_if #(
  parameter int unsigned NUM_CH = 4
);
  localparam int unsigned AW = $clog2(NUM_CH) + 3;

  logic [AW-1:0] address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/multi_channel_interval_timer.sv
// NUM_CH independent down-counting interval timers behind one Avalon-MM slave.
// Each channel: prescaler, period, snapshot, one-shot/continuous mode, interrupt.
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous active-high reset
//   bus      Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   irq      OR of irq_vec
//   irq_vec  per-channel TO & ITO
//   pwm_out  per-channel PWM, registered
// Optional feature macro: MULTI_TIMER_PWM_EN enables the COMPARE register and PWM outputs;
// when undefined COMPARE reads 0 and pwm_out is tied low.
module multi_channel_interval_timer #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned COUNTER_W    = 32,
  parameter int unsigned PRESCALE_W   = 8,
  parameter int unsigned RESET_PERIOD = 49999
) (
  input  logic                           clk,
  input  logic                           reset,
  multi_channel_interval_timer_if.slave  bus,
  output logic                           irq,
  output logic [NUM_CH-1:0]              irq_vec,
  output logic [NUM_CH-1:0]              pwm_out
);
  localparam logic [COUNTER_W-1:0] ResetCount = COUNTER_W'(RESET_PERIOD);

  logic [NUM_CH-1:0]     run_q, run_d, to_q, to_d, cont_q, cont_d, ito_q, ito_d;
  logic [NUM_CH-1:0]     tick, timeout;
  logic [COUNTER_W-1:0]  period_q [NUM_CH];
  logic [COUNTER_W-1:0]  period_d [NUM_CH];
  logic [COUNTER_W-1:0]  count_q  [NUM_CH];
  logic [COUNTER_W-1:0]  count_d  [NUM_CH];
  logic [COUNTER_W-1:0]  snap_q   [NUM_CH];
  logic [COUNTER_W-1:0]  snap_d   [NUM_CH];
  logic [PRESCALE_W-1:0] prescale_q [NUM_CH];
  logic [PRESCALE_W-1:0] prescale_d [NUM_CH];
  logic [PRESCALE_W-1:0] pcnt_q [NUM_CH];
  logic [PRESCALE_W-1:0] pcnt_d [NUM_CH];
`ifdef MULTI_TIMER_PWM_EN
  logic [COUNTER_W-1:0]  compare_q [NUM_CH];
  logic [COUNTER_W-1:0]  compare_d [NUM_CH];
  logic [NUM_CH-1:0]     pwm_q, pwm_d;
`endif
  logic [31:0]           readdata_q, readdata_d;
  logic                  wr_en;
  int unsigned           ch_sel;
  logic [2:0]            reg_sel;

  assign wr_en   = bus.chipselect & ~bus.write_n;
  assign ch_sel  = 32'(bus.address) >> 3;
  assign reg_sel = bus.address[2:0];

  // Read decode; channels >= NUM_CH never match and read 0.
  always_comb begin
    readdata_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_sel == i) begin
        case (reg_sel)
          3'd0: readdata_d = 32'({run_q[i], to_q[i]});
          3'd1: readdata_d = 32'({cont_q[i], ito_q[i]});
          3'd2: readdata_d = 32'(period_q[i]);
          3'd3: readdata_d = 32'(snap_q[i]);
          3'd4: readdata_d = 32'(prescale_q[i]);
`ifdef MULTI_TIMER_PWM_EN
          3'd5: readdata_d = 32'(compare_q[i]);
`endif
          default: readdata_d = '0;
        endcase
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      run_d[i]      = run_q[i];
      to_d[i]       = to_q[i];
      cont_d[i]     = cont_q[i];
      ito_d[i]      = ito_q[i];
      period_d[i]   = period_q[i];
      count_d[i]    = count_q[i];
      snap_d[i]     = snap_q[i];
      prescale_d[i] = prescale_q[i];
      pcnt_d[i]     = pcnt_q[i];
`ifdef MULTI_TIMER_PWM_EN
      compare_d[i]  = compare_q[i];
      pwm_d[i]      = run_q[i] & (count_q[i] < compare_q[i]);
`endif
      tick[i]    = run_q[i] & (pcnt_q[i] == '0);
      timeout[i] = tick[i] & (count_q[i] == '0);

      if (run_q[i]) begin
        pcnt_d[i] = tick[i] ? prescale_q[i] : pcnt_q[i] - 1'b1;
      end
      if (tick[i]) begin
        count_d[i] = timeout[i] ? period_q[i] : count_q[i] - 1'b1;
      end
      if (timeout[i]) begin
        to_d[i] = 1'b1;
        if (!cont_q[i]) run_d[i] = 1'b0;
      end

      // Register writes override the free-running updates above.
      if (wr_en && (ch_sel == i)) begin
        case (reg_sel)
          3'd0: if (!timeout[i]) to_d[i] = 1'b0;  // a coincident timeout wins
          3'd1: begin
            cont_d[i] = bus.writedata[1];
            ito_d[i]  = bus.writedata[0];
            if (bus.writedata[2])      run_d[i] = 1'b1;  // START beats STOP
            else if (bus.writedata[3]) run_d[i] = 1'b0;
          end
          3'd2: begin
            period_d[i] = bus.writedata[COUNTER_W-1:0];
            count_d[i]  = bus.writedata[COUNTER_W-1:0];
            pcnt_d[i]   = prescale_q[i];
            run_d[i]    = 1'b0;
          end
          3'd3: snap_d[i] = count_q[i];
          3'd4: begin
            prescale_d[i] = bus.writedata[PRESCALE_W-1:0];
            pcnt_d[i]     = bus.writedata[PRESCALE_W-1:0];
          end
`ifdef MULTI_TIMER_PWM_EN
          3'd5: compare_d[i] = bus.writedata[COUNTER_W-1:0];
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_q <= '0;
      run_q      <= '0;
      to_q       <= '0;
      cont_q     <= '0;
      ito_q      <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        period_q[i]   <= ResetCount;
        count_q[i]    <= ResetCount;
        snap_q[i]     <= '0;
        prescale_q[i] <= '0;
        pcnt_q[i]     <= '0;
`ifdef MULTI_TIMER_PWM_EN
        compare_q[i]  <= '0;
`endif
      end
`ifdef MULTI_TIMER_PWM_EN
      pwm_q <= '0;
`endif
    end else begin
      readdata_q <= readdata_d;
      run_q      <= run_d;
      to_q       <= to_d;
      cont_q     <= cont_d;
      ito_q      <= ito_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        period_q[i]   <= period_d[i];
        count_q[i]    <= count_d[i];
        snap_q[i]     <= snap_d[i];
        prescale_q[i] <= prescale_d[i];
        pcnt_q[i]     <= pcnt_d[i];
`ifdef MULTI_TIMER_PWM_EN
        compare_q[i]  <= compare_d[i];
`endif
      end
`ifdef MULTI_TIMER_PWM_EN
      pwm_q <= pwm_d;
`endif
    end
  end

  assign bus.readdata = readdata_q;
  assign irq_vec      = to_q & ito_q;
  assign irq          = |irq_vec;
`ifdef MULTI_TIMER_PWM_EN
  assign pwm_out      = pwm_q;
`else
  assign pwm_out      = '0;
`endif
endmodule
